uart_dir_decoder: RTL and testbench

//  Sits between rxuart and snake: turns received ASCII bytes (dataRX/WR_RX) into a

---
 rtl/uart_dir_decoder_pkg.sv | 57 +++++
 rtl/uart_dir_decoder_if.sv | 21 ++
 rtl/uart_dir_decoder_dir_fifo.sv | 52 +++++
 rtl/uart_dir_decoder.sv | 86 ++++++++
 tb/tb_uart_dir_decoder.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/uart_dir_decoder_pkg.sv
// Shared snake definitions: direction codes, ASCII key constants, key decode helper.
package uart_dir_decoder_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_DIR,
    CMD_PAUSE,
    CMD_RESTART
  } cmd_e;

  typedef struct packed {
    cmd_e cmd;
    dir_e dir;
  } key_t;

  localparam logic [7:0] KEY_UP_LC      = 8'h77;  // w
  localparam logic [7:0] KEY_UP_UC      = 8'h57;  // W
  localparam logic [7:0] KEY_RIGHT_LC   = 8'h64;  // d
  localparam logic [7:0] KEY_RIGHT_UC   = 8'h44;  // D
  localparam logic [7:0] KEY_DOWN_LC    = 8'h73;  // s
  localparam logic [7:0] KEY_DOWN_UC    = 8'h53;  // S
  localparam logic [7:0] KEY_LEFT_LC    = 8'h61;  // a
  localparam logic [7:0] KEY_LEFT_UC    = 8'h41;  // A
  localparam logic [7:0] KEY_PAUSE_LC   = 8'h70;  // p
  localparam logic [7:0] KEY_PAUSE_UC   = 8'h50;  // P
  localparam logic [7:0] KEY_RESTART_LC = 8'h72;  // r
  localparam logic [7:0] KEY_RESTART_UC = 8'h52;  // R

  // Directions are encoded so that the 180-degree turn differs only in bit 1.
  function automatic dir_e opposite(dir_e d);
    return dir_e'(d ^ 2'b10);
  endfunction

  function automatic key_t decode_key(logic [7:0] b);
    key_t k;
    k.cmd = CMD_NONE;
    k.dir = DIR_UP;
    case (b)
      KEY_UP_LC, KEY_UP_UC:           begin k.cmd = CMD_DIR; k.dir = DIR_UP;    end
      KEY_RIGHT_LC, KEY_RIGHT_UC:     begin k.cmd = CMD_DIR; k.dir = DIR_RIGHT; end
      KEY_DOWN_LC, KEY_DOWN_UC:       begin k.cmd = CMD_DIR; k.dir = DIR_DOWN;  end
      KEY_LEFT_LC, KEY_LEFT_UC:       begin k.cmd = CMD_DIR; k.dir = DIR_LEFT;  end
      KEY_PAUSE_LC, KEY_PAUSE_UC:     k.cmd = CMD_PAUSE;
      KEY_RESTART_LC, KEY_RESTART_UC: k.cmd = CMD_RESTART;
      default:                        k.cmd = CMD_NONE;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/uart_dir_decoder_if.sv
// Byte input from rxuart, move tick from snake, and the decoded command outputs.
interface uart_dir_decoder_if;
  logic [7:0] dataRX;
  logic       WR_RX;
  logic       move_tick;
  logic [1:0] dir;
  logic       dir_valid_q;
  logic       paused;
  logic       restart;
  logic       cmd_dropped;

  modport master (
    output dataRX, WR_RX, move_tick,
    input  dir, dir_valid_q, paused, restart, cmd_dropped
  );

  modport slave (
    input  dataRX, WR_RX, move_tick,
    output dir, dir_valid_q, paused, restart, cmd_dropped
  );
endinterface

// File: rtl/uart_dir_decoder_dir_fifo.sv
// 2-bit wide synchronous FIFO of queued directions; tail exposes the newest entry.
module dir_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [1:0] din,
  output logic       full,
  output logic       empty,
  output logic [1:0] head,
  output logic [1:0] tail
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [1:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];
  assign tail    = mem[wr_ptr - PW'(1)];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_dir_decoder.sv
// Decodes received ASCII keys into queued snake directions plus pause/restart control.
module uart_dir_decoder
  import uart_dir_decoder_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [1:0]  START_DIR  = 2'b01
) (
  input logic               clk,
  input logic               rst,
  uart_dir_decoder_if.slave bus
);
  logic [7:0] byte_q;
  logic       byte_vld_q;
  dir_e       dir_r;
  logic       paused_r;
  logic       restart_r;
  logic       dropped_r;

  key_t       key;
  dir_e       ref_dir;
  logic       dir_key;
  logic       drop;
  logic       push;
  logic       pop;
  logic       do_restart;
  logic       do_pause;
  logic       full;
  logic       empty;
  logic [1:0] head;
  logic [1:0] tail;

  dir_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (do_restart),
    .din   (key.dir),
    .full  (full),
    .empty (empty),
    .head  (head),
    .tail  (tail)
  );

  // Reference is the newest queued entry, so filtering applies to where the snake will be heading.
  always_comb begin
    key        = decode_key(byte_q);
    ref_dir    = empty ? dir_r : dir_e'(tail);
    dir_key    = byte_vld_q && (key.cmd == CMD_DIR);
    do_pause   = byte_vld_q && (key.cmd == CMD_PAUSE);
    do_restart = byte_vld_q && (key.cmd == CMD_RESTART);
    drop       = dir_key && (paused_r || (key.dir == ref_dir) ||
                             (key.dir == opposite(ref_dir)) || full);
    push       = dir_key && !drop;
    pop        = bus.move_tick && !paused_r && !empty && !do_restart;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_q     <= '0;
      byte_vld_q <= 1'b0;
      dir_r      <= dir_e'(START_DIR);
      paused_r   <= 1'b0;
      restart_r  <= 1'b0;
      dropped_r  <= 1'b0;
    end else begin
      byte_q     <= bus.dataRX;
      byte_vld_q <= bus.WR_RX;
      restart_r  <= do_restart;
      dropped_r  <= drop;
      if (do_restart) begin
        dir_r    <= dir_e'(START_DIR);
        paused_r <= 1'b0;
      end else begin
        if (pop)      dir_r    <= dir_e'(head);
        if (do_pause) paused_r <= ~paused_r;
      end
    end
  end

  assign bus.dir         = dir_r;
  assign bus.dir_valid_q = !empty;
  assign bus.paused      = paused_r;
  assign bus.restart     = restart_r;
  assign bus.cmd_dropped = dropped_r;
endmodule

// File: tb/tb_uart_dir_decoder.sv
// Scoreboard bench: a queue-based key model predicts outputs after every edge; a monitor compares.
module tb_uart_dir_decoder;
  localparam int unsigned DEPTH = 4;
  localparam logic [1:0]  START = 2'b01;

  logic clk = 1'b0;
  logic rst;
  always #20 clk = ~clk;

  uart_dir_decoder_if bus();

  uart_dir_decoder #(.FIFO_DEPTH(DEPTH), .START_DIR(START)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0] dir;
    logic       valid;
    logic       paused;
    logic       restart;
    logic       dropped;
  } snap_t;

  snap_t       exp_q[$];
  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [1:0] m_dir;
  logic [1:0] m_q[$];
  logic       m_paused;
  logic       m_restart;
  logic       m_dropped;
  logic       m_pend;
  logic [7:0] m_pend_byte;

  // 0 = ignored, 1 = direction (k), 2 = pause, 3 = restart
  function automatic int classify(input logic [7:0] b, output logic [1:0] k);
    logic [7:0] c;
    c = b;
    k = 2'b00;
    if (b >= 8'h41 && b <= 8'h5A) c = b + 8'h20;
    case (c)
      8'h77:   begin k = 2'b00; return 1; end
      8'h64:   begin k = 2'b01; return 1; end
      8'h73:   begin k = 2'b10; return 1; end
      8'h61:   begin k = 2'b11; return 1; end
      8'h70:   return 2;
      8'h72:   return 3;
      default: return 0;
    endcase
  endfunction

  task automatic model_step(input logic r, input logic [7:0] b, input logic wr, input logic tick);
    int         cls;
    logic [1:0] k;
    logic [1:0] refd;
    logic       do_pop;
    logic       do_push;
    if (r) begin
      m_dir = START; m_q.delete(); m_paused = 1'b0;
      m_restart = 1'b0; m_dropped = 1'b0; m_pend = 1'b0; m_pend_byte = 8'h00;
    end else begin
      cls = 0;
      k = 2'b00;
      if (m_pend) cls = classify(m_pend_byte, k);
      m_restart = 1'b0;
      m_dropped = 1'b0;
      if (cls == 3) begin
        m_q.delete(); m_dir = START; m_paused = 1'b0; m_restart = 1'b1;
      end else begin
        do_pop  = tick && !m_paused && (m_q.size() > 0);
        do_push = 1'b0;
        if (cls == 1) begin
          refd = (m_q.size() > 0) ? m_q[m_q.size()-1] : m_dir;
          if (m_paused || k == refd || k == (refd ^ 2'b10) || m_q.size() >= DEPTH)
            m_dropped = 1'b1;
          else
            do_push = 1'b1;
        end
        if (do_pop)  m_dir = m_q.pop_front();
        if (do_push) m_q.push_back(k);
        if (cls == 2) m_paused = !m_paused;
      end
      m_pend = wr;
      m_pend_byte = b;
    end
  endtask

  // Inputs are held across one edge; the model then predicts the state after that edge.
  task automatic step(input logic r, input logic [7:0] b, input logic wr, input logic tick);
    snap_t s;
    rst = r; bus.dataRX = b; bus.WR_RX = wr; bus.move_tick = tick;
    @(posedge clk);
    model_step(r, b, wr, tick);
    s.dir = m_dir; s.valid = (m_q.size() > 0); s.paused = m_paused;
    s.restart = m_restart; s.dropped = m_dropped;
    exp_q.push_back(s);
    #1;
  endtask

  task automatic key(input logic [7:0] b);
    step(1'b0, b, 1'b1, 1'b0);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic tick();
    step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: actual=%b required=%b", name, $time, act, req);
    end
  endtask

  initial begin
    snap_t s;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        s = exp_q.pop_front();
        chk("dir",         bus.dir,                 s.dir);
        chk("dir_valid_q", {1'b0, bus.dir_valid_q}, {1'b0, s.valid});
        chk("paused",      {1'b0, bus.paused},      {1'b0, s.paused});
        chk("restart",     {1'b0, bus.restart},     {1'b0, s.restart});
        chk("cmd_dropped", {1'b0, bus.cmd_dropped}, {1'b0, s.dropped});
      end
    end
  end

  logic [7:0] pick_tbl [16];

  initial begin
    int unsigned budget;
    logic [7:0]  b;
    rst = 1'b1; bus.dataRX = 8'h00; bus.WR_RX = 1'b0; bus.move_tick = 1'b0;
    pick_tbl = '{8'h77, 8'h57, 8'h61, 8'h41, 8'h73, 8'h53, 8'h64, 8'h44,
                 8'h77, 8'h61, 8'h73, 8'h64, 8'h70, 8'h72, 8'h78, 8'h00};
    repeat (3) step(1'b1, 8'h00, 1'b0, 1'b0);

    // 'w' queues UP, tick consumes it
    key(8'h77); idle(2); tick(); idle(1);
    // reset to RIGHT, then reversal 'a' and no-op 'D'
    step(1'b1, 8'h00, 1'b0, 1'b0);
    key(8'h61); key(8'h44); idle(3);
    // burst w,a,w,d,s: last one drops as full; then drain
    key(8'h77); key(8'h61); key(8'h77); key(8'h64); key(8'h73); idle(2);
    for (int unsigned i = 0; i < 4; i++) begin tick(); idle(1); end
    tick(); idle(1);
    // pause blocks keys and ticks
    key(8'h70); idle(2); key(8'h73); idle(1); tick(); idle(2); key(8'h50); idle(2);
    // restart coincident with a tick while two entries are queued
    key(8'h77); key(8'h61); idle(2); key(8'h72); tick(); idle(2);
    // ignored bytes, then reset while a decode is pending
    key(8'h78); key(8'h00); idle(2);
    key(8'h77); step(1'b1, 8'h00, 1'b0, 1'b0); idle(3);

    for (int unsigned i = 0; i < 3000; i++) begin
      b = pick_tbl[$urandom_range(0, 15)];
      if (b == 8'h00) b = 8'($urandom);
      step(($urandom_range(0, 299) == 0), b, ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 3) == 0));
    end
    idle(2);

    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    #5;
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
